// File: rtl/instr_fetch_unit.sv
// Front end: owns the PC, drives a 1-cycle synchronous imem and presents decoded fields.
// Start/branch cost one bubble; stall holds the presented word by re-reading instr_pc.
module instr_fetch_unit #(
  parameter int          PC_W    = 10,
  parameter int          INSTR_W = 9,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter int          CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic               TYP,
  output logic [3:0]         OP,
  output logic [3:0]         OPND,
  output logic [PC_W-1:0]    instr_pc,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire;
  logic              is_halt;

  assign is_halt     = (imem_data[8] == 1'b0) && (imem_data[7:4] == HALT_OP);
  assign instr_valid = (state_q == RUN);
  assign TYP         = instr_valid & imem_data[8];
  assign OP          = instr_valid ? imem_data[7:4] : 4'h0;
  assign OPND        = instr_valid ? imem_data[3:0] : 4'h0;
  assign instr_pc    = instr_pc_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      instr_pc_q <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_pc_q <= instr_pc_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_pc_d = instr_pc_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    imem_addr  = fetch_pc_q;
    retire     = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          imem_addr  = start_addr;
          instr_pc_d = start_addr;
          fetch_pc_d = start_addr + PC_ONE;
          done_d     = 1'b0;
          cnt_d      = '0;
          state_d    = PRIME;
        end
      end
      PRIME: begin
        // Re-issue instr_pc so the word landing in the first RUN cycle matches instr_pc.
        imem_addr = instr_pc_q;
        if ((instr_pc_q + PC_ONE) != fetch_pc_q)
          fetch_pc_d = fetch_pc_q + PC_ONE;
        state_d = RUN;
      end
      RUN: begin
        if (stall) begin
          imem_addr = instr_pc_q;
        end else if (is_halt) begin
          retire  = 1'b1;
          done_d  = 1'b1;
          state_d = HALT;
        end else if (br_taken) begin
          retire     = 1'b1;
          imem_addr  = br_target;
          instr_pc_d = br_target;
          fetch_pc_d = br_target + PC_ONE;
          state_d    = PRIME;
        end else begin
          retire     = 1'b1;
          instr_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_ONE;
  end

endmodule
